// File: rtl/prim_reg_bus_if.sv
// Bus-to-register-slice adapter: one valid/ready request at a time, decoded into a
// single-cycle write/read strobe for a CSR bank, with a captured valid/ready response.
module prim_reg_bus_if #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int NREG       = 16,
  parameter int PARTIAL_WR = 0,
  localparam int NB        = DW / 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_write_i,
  input  logic [AW-1:0]      req_addr_i,
  input  logic [DW-1:0]      req_wdata_i,
  input  logic [NB-1:0]      req_be_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DW-1:0]      rsp_rdata_o,
  output logic               rsp_error_o,
  output logic [NREG-1:0]    reg_we_o,
  output logic [NREG-1:0]    reg_re_o,
  output logic [DW-1:0]      reg_wd_o,
  output logic [NB-1:0]      reg_be_o,
  input  logic [NREG*DW-1:0] reg_rdata_i
);

  localparam int OB = $clog2(NB);
  localparam int IW = AW - OB;
  localparam logic [IW:0] NREG_W = (IW+1)'(NREG);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state;
  logic            write_q;
  logic            err_q;
  logic [IW-1:0]   idx_q;

  logic [IW-1:0]   idx_in;
  logic            misalign;
  logic            range_err;
  logic            wr_err;
  logic            acc_err;
  logic            do_strobe;
  logic [NREG-1:0] onehot;
  logic [DW-1:0]   sel_rdata;

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  always_comb begin
    idx_in    = req_addr_i[AW-1:OB];
    misalign  = |req_addr_i[OB-1:0];
    range_err = ({1'b0, idx_in} >= NREG_W);
    wr_err    = req_write_i && (PARTIAL_WR == 0) && !(&req_be_i);
    acc_err   = misalign || range_err || wr_err;
    // A fully-masked write is a legal no-op when partial writes are allowed.
    do_strobe = !acc_err && !(req_write_i && !(|req_be_i));
    onehot    = NREG'(1) << idx_in;
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx_q == IW'(i)) sel_rdata = reg_rdata_i[i*DW +: DW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      reg_we_o    <= '0;
      reg_re_o    <= '0;
      reg_wd_o    <= '0;
      reg_be_o    <= '0;
    end else begin
      reg_we_o <= '0;
      reg_re_o <= '0;
      case (state)
        // Accept: latch the request and raise the strobe for the ACCESS cycle.
        IDLE: begin
          if (req_valid_i) begin
            write_q  <= req_write_i;
            idx_q    <= idx_in;
            err_q    <= acc_err;
            reg_wd_o <= req_wdata_i;
            reg_be_o <= req_be_i;
            if (do_strobe) begin
              if (req_write_i) reg_we_o <= onehot;
              else             reg_re_o <= onehot;
            end
            state <= ACCESS;
          end
        end
        // Capture read data at the strobe edge so read-clear registers return
        // their value before the clear takes effect.
        ACCESS: begin
          rsp_error_o <= err_q;
          rsp_rdata_o <= (!write_q && !err_q) ? sel_rdata : '0;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prim_reg_bus_if.sv
// Directed bench for prim_reg_bus_if: a vector table of single transactions plus
// hand sequences for response backpressure and reset during a write.
module tb_prim_reg_bus_if;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [7:0]   req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [3:0]   req_be = '0;
  logic         rsp_ready = 1'b1;
  logic [511:0] rdata_bus;

  logic         req_ready0, rsp_valid0, err0;
  logic [31:0]  rdata0, wd0;
  logic [15:0]  we0, re0;
  logic [3:0]   be0;
  logic         req_ready1, rsp_valid1, err1;
  logic [31:0]  rdata1, wd1;
  logic [15:0]  we1, re1;
  logic [3:0]   be1;

  logic [31:0]  regs [16];
  logic         loaded = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prim_reg_bus_if #(.PARTIAL_WR(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready0),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rdata0), .rsp_error_o(err0), .reg_we_o(we0), .reg_re_o(re0),
    .reg_wd_o(wd0), .reg_be_o(be0), .reg_rdata_i(rdata_bus));

  prim_reg_bus_if #(.PARTIAL_WR(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready1),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rdata1), .rsp_error_o(err1), .reg_we_o(we1), .reg_re_o(re1),
    .reg_wd_o(wd1), .reg_be_o(be1), .reg_rdata_i(rdata_bus));

  // Register bank model, written only by the PARTIAL_WR=0 instance.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) regs[i] <= {4'h0, 4'(i), 24'hC0FFEE};
      regs[3] <= 32'h12345678;
      loaded  <= 1'b1;
    end else begin
      for (int i = 0; i < 16; i++)
        if (we0[i])
          for (int k = 0; k < 4; k++)
            if (be0[k]) regs[i][8*k +: 8] <= wd0[8*k +: 8];
    end
  end

  always_comb begin
    rdata_bus = '0;
    for (int i = 0; i < 16; i++) rdata_bus[i*32 +: 32] = regs[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [15:0] we;
    logic [15:0] re;
    logic [31:0] rd;
    logic        err;
    logic [15:0] we1;
    logic        err1;
  } vec_t;

  vec_t vt [14];

  logic [15:0] s_we, s_re, s_we1, s_after;
  logic [31:0] s_wd, s_rd, s_rd1;
  logic [3:0]  s_be1;
  logic        s_rv, s_err, s_err1, s_ready;

  // Drive one request from IDLE with rsp_ready held high; samples each phase.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] b);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = b;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    s_we = we0; s_re = re0; s_wd = wd0; s_we1 = we1; s_be1 = be1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    s_rv = rsp_valid0; s_rd = rdata0; s_err = err0; s_err1 = err1; s_rd1 = rdata1;
    s_after = we0 | re0 | we1 | re1;
    @(posedge clk); #1;
    s_ready = req_ready0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 16'h0004, 16'h0000, 32'h0,        1'b0, 16'h0004, 1'b0};
    vt[1]  = '{1'b0, 8'h08, 32'h0,        4'hF, 16'h0000, 16'h0004, 32'hDEADBEEF, 1'b0, 16'h0000, 1'b0};
    vt[2]  = '{1'b0, 8'h0C, 32'h0,        4'hF, 16'h0000, 16'h0008, 32'h12345678, 1'b0, 16'h0000, 1'b0};
    vt[3]  = '{1'b0, 8'h02, 32'h0,        4'hF, 16'h0000, 16'h0000, 32'h0,        1'b1, 16'h0000, 1'b1};
    vt[4]  = '{1'b0, 8'h40, 32'h0,        4'hF, 16'h0000, 16'h0000, 32'h0,        1'b1, 16'h0000, 1'b1};
    vt[5]  = '{1'b1, 8'h10, 32'hCAFE0003, 4'h3, 16'h0000, 16'h0000, 32'h0,        1'b1, 16'h0010, 1'b0};
    vt[6]  = '{1'b0, 8'h3C, 32'h0,        4'hF, 16'h0000, 16'h8000, 32'h0FC0FFEE, 1'b0, 16'h0000, 1'b0};
    vt[7]  = '{1'b0, 8'h0D, 32'h0,        4'hF, 16'h0000, 16'h0000, 32'h0,        1'b1, 16'h0000, 1'b1};
    vt[8]  = '{1'b1, 8'h3C, 32'h11111111, 4'h0, 16'h0000, 16'h0000, 32'h0,        1'b1, 16'h0000, 1'b0};
    vt[9]  = '{1'b1, 8'h04, 32'hA5A55A5A, 4'hF, 16'h0002, 16'h0000, 32'h0,        1'b0, 16'h0002, 1'b0};
    vt[10] = '{1'b0, 8'h04, 32'h0,        4'h0, 16'h0000, 16'h0002, 32'hA5A55A5A, 1'b0, 16'h0000, 1'b0};
    vt[11] = '{1'b0, 8'hFC, 32'h0,        4'hF, 16'h0000, 16'h0000, 32'h0,        1'b1, 16'h0000, 1'b1};
    vt[12] = '{1'b0, 8'h10, 32'h0,        4'hF, 16'h0000, 16'h0010, 32'h04C0FFEE, 1'b0, 16'h0000, 1'b0};
    vt[13] = '{1'b1, 8'h40, 32'h77777777, 4'hF, 16'h0000, 16'h0000, 32'h0,        1'b1, 16'h0000, 1'b1};

    #23;
    chk("rst_req_ready", 32'(req_ready0), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    chk("rst_strobes",   32'({we0, re0}), 32'd0);
    chk("rst_wd",        wd0, 32'd0);
    chk("rst_be",        32'(be0), 32'd0);
    chk("rst_rsp",       {rdata0[30:0], err0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_txn(vt[i].w, vt[i].a, vt[i].d, vt[i].b);
      chk($sformatf("v%0d_we", i),    32'(s_we), 32'(vt[i].we));
      chk($sformatf("v%0d_re", i),    32'(s_re), 32'(vt[i].re));
      chk($sformatf("v%0d_wd", i),    s_wd, vt[i].d);
      chk($sformatf("v%0d_rvalid", i), 32'(s_rv), 32'd1);
      chk($sformatf("v%0d_rdata", i), s_rd, vt[i].rd);
      chk($sformatf("v%0d_err", i),   32'(s_err), 32'(vt[i].err));
      chk($sformatf("v%0d_we1", i),   32'(s_we1), 32'(vt[i].we1));
      chk($sformatf("v%0d_err1", i),  32'(s_err1), 32'(vt[i].err1));
      chk($sformatf("v%0d_rdata1", i), s_rd1, vt[i].rd);
      chk($sformatf("v%0d_one_shot", i), 32'(s_after), 32'd0);
      chk($sformatf("v%0d_idle", i),  32'(s_ready), 32'd1);
      if (vt[i].we1 != 16'h0) chk($sformatf("v%0d_be1", i), 32'(s_be1), 32'(vt[i].b));
    end

    // Response backpressure: held response, extra request ignored.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h0C; req_be = 4'hF; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_strobe", 32'(re0), 32'h0008);
    req_write = 1'b1; req_addr = 8'h08; req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), 32'(rsp_valid0), 32'd1);
      chk($sformatf("bp%0d_rdata", c), rdata0, 32'h12345678);
      chk($sformatf("bp%0d_err", c),   32'(err0), 32'd0);
      chk($sformatf("bp%0d_ready", c), 32'(req_ready0), 32'd0);
      chk($sformatf("bp%0d_strobe", c), 32'(we0 | re0), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_release_ready", 32'(req_ready0), 32'd1);
    chk("bp_release_valid", 32'(rsp_valid0), 32'd0);
    @(posedge clk); #1;
    chk("bp_no_strobe", 32'(we0 | re0), 32'd0);
    run_txn(1'b0, 8'h08, 32'h0, 4'hF);
    chk("bp_reg2_kept", s_rd, 32'hDEADBEEF);

    // Reset asserted during the ACCESS cycle of a write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h14; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_strobe", 32'(we0), 32'h0020);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_we_drop",    32'(we0 | we1), 32'd0);
    chk("rw_rsp_valid",  32'(rsp_valid0), 32'd0);
    chk("rw_req_ready",  32'(req_ready0), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rw_after_ready", 32'(req_ready0), 32'd1);
    chk("rw_after_valid", 32'(rsp_valid0), 32'd0);
    run_txn(1'b0, 8'h14, 32'h0, 4'hF);
    chk("rw_reg5_kept", s_rd, 32'h05C0FFEE);
    chk("rw_reg5_err",  32'(s_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
